// File: rtl/nios2_jtag_debug_cmd_queue.sv
// Nios II JTAG debug command queue: toggle synchronisers, snapshot FIFO
// and per-instruction action strobes on the system clock.
module nios2_jtag_debug_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int DR_W        = 38,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     uir_toggle,
  input  logic                     udr_toggle,
  input  logic [IR_W-1:0]          ir_in,
  input  logic [DR_W-1:0]          sr,
  input  logic                     cmd_ready,
  input  logic                     clear_ovf,
  output logic                     cmd_valid,
  output logic [IR_W-1:0]          cmd_ir,
  output logic [DR_W-1:0]          jdo,
  output logic [2**IR_W-1:0]       take_action,
  output logic [2**IR_W-1:0]       take_no_action,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = IR_W + DR_W;
  localparam int PW = $clog2(SYNC_STAGES + 2);

  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] udr_sync;
  logic                   uir_prev;
  logic                   udr_prev;
  logic [PW-1:0]          prime_cnt;
  logic                   primed;
  logic                   uir_evt;
  logic                   udr_evt;

  logic [IR_W-1:0] ir_reg;
  logic [EW-1:0]   mem [DEPTH];
  logic [LW-1:0]   wr_cnt;
  logic [LW-1:0]   rd_cnt;
  logic [EW-1:0]   head;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  assign primed  = (prime_cnt == PW'(SYNC_STAGES + 1));
  assign uir_evt = primed && (uir_sync[SYNC_STAGES-1] ^ uir_prev);
  assign udr_evt = primed && (udr_sync[SYNC_STAGES-1] ^ udr_prev);

  // prev always follows the sync output, so priming just masks the XOR
  always_ff @(posedge clk) begin
    if (reset) begin
      uir_sync  <= '0;
      udr_sync  <= '0;
      uir_prev  <= 1'b0;
      udr_prev  <= 1'b0;
      prime_cnt <= '0;
    end else begin
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], uir_toggle};
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], udr_toggle};
      uir_prev <= uir_sync[SYNC_STAGES-1];
      udr_prev <= udr_sync[SYNC_STAGES-1];
      if (!primed) prime_cnt <= prime_cnt + PW'(1);
    end
  end

  assign level     = wr_cnt - rd_cnt;
  assign cmd_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign pop       = cmd_valid && cmd_ready;
  assign push      = udr_evt && (!full || pop);
  assign drop      = udr_evt && full && !pop;

  assign head   = mem[rd_cnt[AW-1:0]];
  assign cmd_ir = head[EW-1 -: IR_W];
  assign jdo    = head[DR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_reg   <= '0;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (uir_evt) ir_reg <= ir_in;
      if (push) wr_cnt <= wr_cnt + LW'(1);
      if (pop) rd_cnt <= rd_cnt + LW'(1);
      if (drop) overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // ir_reg here is the pre-update value when both events coincide
  always_ff @(posedge clk) begin
    if (push) mem[wr_cnt[AW-1:0]] <= {ir_reg, sr};
  end

  always_comb begin
    take_action    = '0;
    take_no_action = '0;
    if (pop) begin
      if (jdo[DR_W-1]) take_action[cmd_ir] = 1'b1;
      else take_no_action[cmd_ir] = 1'b1;
    end
  end

endmodule

// File: tb/tb_nios2_jtag_debug_cmd_queue.sv
// Randomised and directed bench for nios2_jtag_debug_cmd_queue
// against a queue-based behavioural model.
module tb_nios2_jtag_debug_cmd_queue;

  localparam int IR_W  = 2;
  localparam int DR_W  = 38;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            uir_toggle;
  logic            udr_toggle;
  logic [1:0]      ir_in;
  logic [37:0]     sr;
  logic            cmd_ready;
  logic            clear_ovf;
  logic            cmd_valid;
  logic [1:0]      cmd_ir;
  logic [37:0]     jdo;
  logic [3:0]      take_action;
  logic [3:0]      take_no_action;
  logic            overflow;
  logic [2:0]      level;

  nios2_jtag_debug_cmd_queue #(
    .IR_W(IR_W), .DR_W(DR_W), .DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset),
    .uir_toggle(uir_toggle), .udr_toggle(udr_toggle),
    .ir_in(ir_in), .sr(sr),
    .cmd_ready(cmd_ready), .clear_ovf(clear_ovf),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .jdo(jdo),
    .take_action(take_action), .take_no_action(take_no_action),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rst_cyc = 0;

  logic [39:0] mq[$];
  logic [1:0]  m_ir;
  logic        m_ovf;
  int          uq[$];
  int          dq[$];

  logic        e_valid, a_valid;
  logic [1:0]  e_ir, a_ir;
  logic [37:0] e_jdo, a_jdo;
  logic [3:0]  e_act, a_act, e_nact, a_nact;
  logic        e_ovf, a_ovf;
  logic [2:0]  e_lvl, a_lvl;

  logic [37:0] vals[5];

  // one clock: drive, sample expected vs actual, then advance the model
  task automatic tick(input logic rst, input logic rdy, input logic clr,
                      input logic tu, input logic td);
    logic fu, fd, mpop, full;
    reset = rst;
    cmd_ready = rdy;
    clear_ovf = clr;
    if (tu) begin uir_toggle = ~uir_toggle; uq.push_back(cyc + 3); end
    if (td) begin udr_toggle = ~udr_toggle; dq.push_back(cyc + 3); end
    #1;
    e_valid = (mq.size() > 0);
    e_ir    = e_valid ? mq[0][39:38] : 2'd0;
    e_jdo   = e_valid ? mq[0][37:0] : 38'd0;
    e_act   = '0;
    e_nact  = '0;
    if (e_valid && rdy) begin
      if (e_jdo[37]) e_act = 4'(1 << e_ir);
      else e_nact = 4'(1 << e_ir);
    end
    e_ovf  = m_ovf;
    e_lvl  = 3'(mq.size());
    a_valid = cmd_valid;
    a_ir    = cmd_ir;
    a_jdo   = jdo;
    a_act   = take_action;
    a_nact  = take_no_action;
    a_ovf   = overflow;
    a_lvl   = level;
    @(posedge clk);
    cyc++;
    if (rst) begin
      mq.delete(); uq.delete(); dq.delete();
      m_ir = '0; m_ovf = 1'b0; rst_cyc = cyc;
    end else begin
      fu = 1'b0; fd = 1'b0;
      if (uq.size() > 0 && uq[0] == cyc) begin void'(uq.pop_front()); fu = 1'b1; end
      if (dq.size() > 0 && dq[0] == cyc) begin void'(dq.pop_front()); fd = 1'b1; end
      if (cyc <= rst_cyc + 3) begin fu = 1'b0; fd = 1'b0; end
      full = (mq.size() == DEPTH);
      mpop = rdy && (mq.size() > 0);
      if (mpop) void'(mq.pop_front());
      if (fd) begin
        if (!full || mpop) mq.push_back({m_ir, sr});
        else m_ovf = 1'b1;
      end
      if (!(fd && full && !mpop) && clr) m_ovf = 1'b0;
      if (fu) m_ir = ir_in;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, rdy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset;
    udr_toggle = 1'b1;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (a_valid !== 1'b0 || a_lvl !== 3'd0 || a_ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_idle cyc=%0d valid=%b lvl=%0d ovf=%b want 0 0 0",
                 i, a_valid, a_lvl, a_ovf);
      end
    end
  endtask

  task automatic test_action;
    ir_in = 2'd2;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    sr = 38'h20_0000_1234;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_valid !== 1'b1 || a_ir !== 2'd2 || a_jdo !== 38'h20_0000_1234 ||
        a_act !== 4'b0100 || a_nact !== 4'b0000) begin
      miscompares++;
      $display("FAIL action_pop valid=%b ir=%0d jdo=%h act=%b nact=%b want 1 2 2000001234 0100 0000",
               a_valid, a_ir, a_jdo, a_act, a_nact);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_valid !== 1'b0 || a_act !== 4'b0000 || a_nact !== 4'b0000) begin
      miscompares++;
      $display("FAIL action_after valid=%b act=%b nact=%b want 0 0000 0000",
               a_valid, a_act, a_nact);
    end
  endtask

  task automatic test_no_action;
    ir_in = 2'd1;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    sr = 38'h0F_1234_5678;
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(2, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_valid !== 1'b1 || a_ir !== 2'd1 || a_act !== 4'b0000 ||
        a_nact !== 4'b0010) begin
      miscompares++;
      $display("FAIL no_action valid=%b ir=%0d act=%b nact=%b want 1 1 0000 0010",
               a_valid, a_ir, a_act, a_nact);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_act !== 4'b0000 || a_nact !== 4'b0000) begin
      miscompares++;
      $display("FAIL no_action_after act=%b nact=%b want 0000 0000", a_act, a_nact);
    end
  endtask

  task automatic test_overflow;
    ir_in = 2'd3;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      vals[k] = 38'(k * 38'h11_1111_1111 + (k[0] ? 38'h20_0000_0000 : 38'h0));
      sr = vals[k];
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(3, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_lvl !== 3'd4 || a_ovf !== 1'b1 || a_lvl !== e_lvl || a_ovf !== e_ovf) begin
      miscompares++;
      $display("FAIL ovf_full lvl=%0d ovf=%b want 4 1", a_lvl, a_ovf);
    end
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (a_valid !== 1'b1 || a_jdo !== vals[k] || a_ir !== 2'd3 ||
          a_act !== e_act || a_nact !== e_nact) begin
        miscompares++;
        $display("FAIL ovf_order k=%0d jdo=%h ir=%0d act=%b nact=%b want %h 3 %b %b",
                 k, a_jdo, a_ir, a_act, a_nact, vals[k], e_act, e_nact);
      end
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_ovf !== 1'b0 || a_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear ovf=%b valid=%b want 0 0", a_ovf, a_valid);
    end
  endtask

  task automatic test_full_pop;
    ir_in = 2'd0;
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(4, 1'b0);
    for (int k = 0; k < 5; k++) begin
      vals[k] = 38'(38'h2A_0000_0000 ^ (k * 38'h0_0101_0101));
      sr = vals[k];
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (k < 4) idle(3, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_jdo !== vals[0] || a_lvl !== 3'd4 || a_act !== 4'b0001) begin
      miscompares++;
      $display("FAIL fullpop_head jdo=%h lvl=%0d act=%b want %h 4 0001",
               a_jdo, a_lvl, a_act, vals[0]);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_lvl !== 3'd4 || a_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL fullpop_level lvl=%0d ovf=%b want 4 0", a_lvl, a_ovf);
    end
    for (int k = 1; k < 5; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (a_jdo !== vals[k] || a_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL fullpop_order k=%0d jdo=%h valid=%b want %h 1",
                 k, a_jdo, a_valid, vals[k]);
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) begin
      sr = 38'(38'h15_5555_0000 + k);
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle(3, 1'b0);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (a_lvl !== 3'd3) begin
      miscompares++;
      $display("FAIL midrst_pre lvl=%0d want 3", a_lvl);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (a_valid !== 1'b0 || a_lvl !== 3'd0) begin
      miscompares++;
      $display("FAIL midrst_post valid=%b lvl=%0d want 0 0", a_valid, a_lvl);
    end
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (a_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_prime i=%0d valid=%b want 0", i, a_valid);
      end
    end
  endtask

  task automatic test_random;
    logic [63:0] r;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) ir_in = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        r = {$urandom(), $urandom()};
        sr = r[37:0];
      end
      tick($urandom_range(0, 149) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 2) == 0);
      vectors++;
      if (a_valid !== e_valid || a_lvl !== e_lvl || a_ovf !== e_ovf ||
          a_act !== e_act || a_nact !== e_nact ||
          (e_valid && (a_ir !== e_ir || a_jdo !== e_jdo))) begin
        miscompares++;
        $display("FAIL random i=%0d got v%b l%0d o%b a%b n%b ir%0d %h want v%b l%0d o%b a%b n%b ir%0d %h",
                 i, a_valid, a_lvl, a_ovf, a_act, a_nact, a_ir, a_jdo,
                 e_valid, e_lvl, e_ovf, e_act, e_nact, e_ir, e_jdo);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    uir_toggle = 1'b0;
    udr_toggle = 1'b0;
    ir_in = '0;
    sr = '0;
    cmd_ready = 1'b0;
    clear_ovf = 1'b0;
    m_ir = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    test_reset();
    test_action();
    test_no_action();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
